serial_comparator_ctrl: RTL

Sequential unsigned magnitude comparator controller. It latches two N-bit operands on a start request and walks them MSB-first, one bit position per clock, through a single-bit compare slice. It stops early at the first differing bit and reports EQ/LT with the same meaning as the combinational N-bit comparator. It replaces the wide cascaded comparator where area matters more than latency, and hands results to downstream logic through a start/done handshake.

---
 rtl/serial_comparator_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/serial_comparator_ctrl.sv
// Serial MSB-first unsigned magnitude comparator: latches A/B on start, checks one bit per cycle.
// Latency m+1 cycles after accept (2..N+1); start outside IDLE is dropped, no queueing.
module serial_comparator_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         EQ,
    output logic         LT
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    idx_d   = IDX_W'(N - 1);
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // First differing bit decides: A is smaller exactly when B holds the 1.
                if (a_q[idx_q] != b_q[idx_q]) begin
                    eq_d    = 1'b0;
                    lt_d    = b_q[idx_q];
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_COMPARE);
    assign done = (state_q == S_DONE);
    assign EQ   = eq_q;
    assign LT   = lt_q;

endmodule
